// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forward selects,
// FSM state encoding and the hard-wired zero register.
package pipeline_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StHalt    = 2'd2
    } state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// EX-stage operand forwarding select for one source register.
// EX/MEM takes precedence over MEM/WB because it holds the younger result.
module fwd_unit
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic       regwrite_mem,
    input  logic [4:0] writeregister_mem,
    input  logic       regwrite_wb,
    input  logic [4:0] writeregister_wb,
    output logic [1:0] fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (regwrite_mem && (writeregister_mem != REG_ZERO) && (writeregister_mem == src)) begin
            fwd = FWD_MEM;
        end else if (regwrite_wb && (writeregister_wb != REG_ZERO) &&
                     (writeregister_wb == src)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use and branch handling, data-memory
// wait stalls with a halting watchdog, forwarding selects and a stall counter.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic [4:0]       rs_ex,
    input  logic [4:0]       rt_ex,
    input  logic             memread_ex,
    input  logic [4:0]       writeregister_ex,
    input  logic             branch_taken_ex,
    input  logic             regwrite_mem,
    input  logic             regwrite_wb,
    input  logic [4:0]       writeregister_mem,
    input  logic [4:0]       writeregister_wb,
    input  logic             dmem_req_mem,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_bubble,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    stall_q;
    logic                load_use;
    logic                run_path;
    logic [1:0]          fwd_a_raw, fwd_b_raw;

    fwd_unit u_fwd_a (
        .src               (rs_ex),
        .regwrite_mem      (regwrite_mem),
        .writeregister_mem (writeregister_mem),
        .regwrite_wb       (regwrite_wb),
        .writeregister_wb  (writeregister_wb),
        .fwd               (fwd_a_raw)
    );

    fwd_unit u_fwd_b (
        .src               (rt_ex),
        .regwrite_mem      (regwrite_mem),
        .writeregister_mem (writeregister_mem),
        .regwrite_wb       (regwrite_wb),
        .writeregister_wb  (writeregister_wb),
        .fwd               (fwd_b_raw)
    );

    assign load_use = memread_ex && (writeregister_ex != REG_ZERO) &&
                      ((writeregister_ex == rs_id) || (writeregister_ex == rt_id));

    assign forward_a   = rst_n ? fwd_a_raw : FWD_RF;
    assign forward_b   = rst_n ? fwd_b_raw : FWD_RF;
    assign halted      = rst_n && (state_q == StHalt);
    assign stall_count = stall_q;

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        state_d      = state_q;
        wait_d       = wait_q;
        run_path     = 1'b0;

        if (!rst_n) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_en     = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            memwb_bubble = 1'b1;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (dmem_req_mem && !dmem_ready) begin
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        idex_en      = 1'b0;
                        exmem_en     = 1'b0;
                        memwb_bubble = 1'b1;
                        state_d      = StMemWait;
                        wait_d       = WAIT_W'(1);
                    end else begin
                        run_path = 1'b1;
                    end
                end
                StMemWait: begin
                    if (!dmem_ready) begin
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        idex_en      = 1'b0;
                        exmem_en     = 1'b0;
                        memwb_bubble = 1'b1;
                        wait_d       = wait_q + WAIT_W'(1);
                        if (wait_d == WAIT_W'(TIMEOUT_CYCLES)) begin
                            state_d = StHalt;
                        end
                    end else begin
                        // Release cycle behaves as an ordinary run cycle.
                        state_d  = StRun;
                        run_path = 1'b1;
                    end
                end
                StHalt: begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    memwb_en = 1'b0;
                end
                default: begin
                    state_d = StRun;
                end
            endcase

            // A taken branch squashes the younger instructions, so any load-use is moot.
            if (run_path) begin
                if (branch_taken_ex) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StRun;
            wait_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (!pc_en && (state_q != StHalt) && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the five-stage pipeline. Drives the load enables, flushes and writeback bubble of the IF/ID, ID/EX, EX/MEM and MEM/WB buffers. Generates EX-stage forwarding selects and handles load-use, taken-branch and multi-cycle data-memory stalls. Includes a wait watchdog and a stall performance counter.

## Interface
- TIMEOUT_CYCLES, 64: maximum consecutive memory-wait cycles before halting (≥2).
- CNT_W, 16: width of the stall counter.
- clk  in  1  system clock; one clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- rs_id, rt_id  in  5 each  source registers of the instruction in ID.
- rs_ex, rt_ex  in  5 each  source registers of the instruction in EX.
- memread_ex  in  1  EX instruction is a load.
- writeregister_ex  in  5  destination of the EX instruction.
- branch_taken_ex  in  1  branch in EX resolved taken.
- regwrite_mem, regwrite_wb  in  1 each  register-write flags at EX/MEM and MEM/WB outputs.
- writeregister_mem, writeregister_wb  in  5 each  destinations at EX/MEM and MEM/WB outputs.
- dmem_req_mem  in  1  load or store active in MEM.
- dmem_ready  in  1  data memory completes this cycle.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage load enables.
- ifid_flush, idex_flush  out  1 each  load a NOP into the buffer on this edge.
- memwb_bubble  out  1  force regwrite and memtoreg to 0 entering MEM/WB.
- forward_a, forward_b  out  2 each  ALU operand select: 00 register file, 10 EX/MEM, 01 MEM/WB.
- halted  out  1  watchdog tripped.
- stall_count  out  CNT_W  saturating count of stalled cycles.

## Operation
- FSM states: RUN, MEM_WAIT, HALT. Reset state is RUN.
- Outputs are combinational from the state and inputs (Mealy). They must act in the cycle of the hazard.
- Priority in RUN: memory wait > taken branch > load-use > normal.
- Memory wait: dmem_req_mem=1 and dmem_ready=0.
  - pc_en, ifid_en, idex_en and exmem_en are 0; memwb_bubble=1; memwb_en=1.
  - Next state is MEM_WAIT; the wait counter loads 1.
- MEM_WAIT while dmem_ready=0: same outputs as a memory wait; the wait counter increments.
  - If the counter reaches TIMEOUT_CYCLES, next state is HALT.
- MEM_WAIT with dmem_ready=1: all enables are 1 and the bubble is 0 in that cycle. Next state is RUN.
- Taken branch: ifid_flush=1 and idex_flush=1; all enables are 1. Any load-use in the same cycle is ignored.
- Load-use: memread_ex=1, writeregister_ex≠0, and writeregister_ex equals rs_id or rt_id.
  - pc_en=0, ifid_en=0, idex_flush=1; the other enables are 1.
  - Lasts one cycle, with no state change.
- HALT: all enables 0, flushes 0, halted=1. Left only by reset.
- Forwarding for rs_ex (rt_ex and forward_b are identical):
  - 10 if regwrite_mem=1, writeregister_mem≠0 and it equals rs_ex.
  - Otherwise 01 if regwrite_wb=1, writeregister_wb≠0 and it equals rs_ex.
  - Otherwise 00. EX/MEM wins a tie.
- stall_count increments on every cycle where pc_en=0 and the state is not HALT. It saturates at all-ones.

## Timing
- While rst_n=0:
  - all enables 0, ifid_flush=1, idex_flush=1, memwb_bubble=1;
  - forward_a and forward_b 00, halted=0;
  - state RUN, counters 0 on the next edge.
- Reset taking effect mid-MEM_WAIT or in HALT returns to RUN after one edge.
- Flushes and enables take effect on the same rising edge as the buffers they control. Stall latency is 0 cycles.
- dmem_ready=1 in the first request cycle: no stall and no FSM transition.
- Watchdog: with dmem_ready held at 0, halted rises after TIMEOUT_CYCLES stalled cycles.

## Structure
- A shared pipeline package holds:
  - the forward-select constants FWD_RF=00, FWD_MEM=10, FWD_WB=01;
  - the state enum;
  - the zero-register constant.
- One sub-module, fwd_unit: purely combinational, instantiated once for rs_ex and rt_ex.
- Hazard detection, FSM, watchdog and counter stay in the top module.

## Test plan
- writeregister_mem=5, regwrite_mem=1, and writeregister_wb=5, regwrite_wb=1, with rs_ex=5 -> forward_a=10. With writeregister_mem=0, rs_ex=0 -> forward_a=00.
- memread_ex=1, writeregister_ex=8, rt_id=8 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_count becomes 1; normal operation in the next cycle.
- Load-use condition plus branch_taken_ex=1 in the same cycle -> ifid_flush=idex_flush=1, pc_en=1, stall_count unchanged.
- dmem_req_mem=1 with dmem_ready low for 3 cycles, then high -> 3 cycles with exmem_en=0 and memwb_bubble=1; release on the 4th cycle; stall_count=3.
- TIMEOUT_CYCLES=4 and dmem_ready stuck at 0 -> halted=1 after 4 stalled cycles. Enables stay 0 until rst_n=0 for one edge, then state RUN and halted=0.
- Assert rst_n=0 during MEM_WAIT -> next cycle state RUN, stall_count=0, forwards 00.
